riscv_wb_arbiter: RTL and testbench

//   Merges the core's instruction and data Wishbone (pipelined, with stall) master ports into one

---
 rtl/riscv_wb_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_riscv_wb_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter
//   Merges the core's instruction (i_*) and data (d_*) pipelined Wishbone master ports onto a
//   single master port (wb_*). Ownership is granted per bus cycle: once a master owns the bus it
//   keeps it while its cyc stays high. An outstanding-transfer counter limits in-flight requests
//   and ensures ACK/ERR are only returned to the master that issued the request.
//
// Parameters
//   OUTST_W      width of the outstanding counter; at most 2**OUTST_W-1 transfers in flight
//
// Configuration macro
//   RISCV_ARB_RR_EN  defined: round-robin on contention (master not granted last wins)
//                    undefined: fixed priority, data master over instruction master
//
// Ports
//   clk_i, reset_ni                     clock, asynchronous active-low reset
//   i_cyc_i/i_stb_i/i_we_i/i_addr_i/i_sel_i/i_data_i   instruction master request
//   i_ack_o/i_err_o/i_stall_o/i_data_o                 instruction master response
//   d_*                                                same set for the data master
//   wb_cyc_o/wb_stb_o/wb_we_o/wb_addr_o/wb_sel_o/wb_data_o   slave-side request
//   wb_ack_i/wb_err_i/wb_stall_i/wb_data_i                   slave-side response
module riscv_wb_arbiter #(
  parameter int unsigned OUTST_W = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  // instruction master
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  input  logic        i_we_i,
  input  logic [29:0] i_addr_i,
  input  logic [3:0]  i_sel_i,
  input  logic [31:0] i_data_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  output logic        i_stall_o,
  output logic [31:0] i_data_o,
  // data master
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  input  logic [29:0] d_addr_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_data_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic        d_stall_o,
  output logic [31:0] d_data_o,
  // slave side
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [29:0] wb_addr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_data_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i,
  input  logic [31:0] wb_data_i
);

  typedef enum logic [1:0] {StIdle, StOwnI, StOwnD} state_e;

  localparam logic [OUTST_W-1:0] CountMax = '1;
  localparam logic [OUTST_W-1:0] CountOne = OUTST_W'(1);

  state_e               state_q, state_d;
  logic [OUTST_W-1:0]   count_q, count_d;

  logic full;
  logic has_outst;
  logic owning;
  logic sel_d;
  logic own_cyc;
  logic accept;
  logic retire;

  assign full      = (count_q == CountMax);
  assign has_outst = (count_q != '0);
  assign owning    = (state_q != StIdle);
  assign sel_d     = (state_q == StOwnD);
  assign own_cyc   = sel_d ? d_cyc_i : i_cyc_i;
  // Responses with nothing outstanding are stray (e.g. after an abort) and are dropped.
  assign retire    = (wb_ack_i | wb_err_i) & has_outst;
  assign accept    = wb_stb_o & ~wb_stall_i;

  // Contention winner in IDLE: 1 selects the data master.
  logic contend_d;

`ifdef RISCV_ARB_RR_EN
  // Last granted master: 0 = instruction, 1 = data.
  logic last_q, last_d;

  assign contend_d = ~last_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    last_d = last_q;
    if (state_q == StIdle && state_d == StOwnD) last_d = 1'b1;
    if (state_q == StIdle && state_d == StOwnI) last_d = 1'b0;
  end
`else
  assign contend_d = 1'b1;
`endif

  // Request mux and owner-steered responses.
  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_addr_o = '0;
    wb_sel_o  = '0;
    wb_data_o = '0;
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    i_stall_o = 1'b1;
    i_data_o  = '0;
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    d_stall_o = 1'b1;
    d_data_o  = '0;
    if (owning) begin
      wb_cyc_o  = own_cyc;
      wb_stb_o  = (sel_d ? d_stb_i : i_stb_i) & ~full;
      wb_we_o   = sel_d ? d_we_i : i_we_i;
      wb_addr_o = sel_d ? d_addr_i : i_addr_i;
      wb_sel_o  = sel_d ? d_sel_i : i_sel_i;
      wb_data_o = sel_d ? d_data_i : i_data_i;
      if (sel_d) begin
        d_stall_o = wb_stall_i | full;
        d_ack_o   = wb_ack_i & has_outst;
        d_err_o   = wb_err_i & has_outst;
        d_data_o  = wb_data_i;
      end else begin
        i_stall_o = wb_stall_i | full;
        i_ack_o   = wb_ack_i & has_outst;
        i_err_o   = wb_err_i & has_outst;
        i_data_o  = wb_data_i;
      end
    end
  end

  // Grant FSM and outstanding counter.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      StIdle: begin
        count_d = '0;
        if (i_cyc_i && d_cyc_i) begin
          state_d = contend_d ? StOwnD : StOwnI;
        end else if (d_cyc_i) begin
          state_d = StOwnD;
        end else if (i_cyc_i) begin
          state_d = StOwnI;
        end
      end
      StOwnI, StOwnD: begin
        if (!own_cyc) begin
          // Abort: anything still in flight is forgotten.
          state_d = StIdle;
          count_d = '0;
        end else if (accept && !retire) begin
          count_d = count_q + CountOne;
        end else if (!accept && retire) begin
          count_d = count_q - CountOne;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
module tb_riscv_wb_arbiter;

  localparam int unsigned OutstW   = 2;
  localparam int          MaxCount = (1 << OutstW) - 1;

  logic        clk;
  logic        rst_n;
  logic        i_cyc, i_stb, i_we;
  logic [29:0] i_addr;
  logic [3:0]  i_sel;
  logic [31:0] i_wdat;
  logic        i_ack, i_err, i_stall;
  logic [31:0] i_rdat;
  logic        d_cyc, d_stb, d_we;
  logic [29:0] d_addr;
  logic [3:0]  d_sel;
  logic [31:0] d_wdat;
  logic        d_ack, d_err, d_stall;
  logic [31:0] d_rdat;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_wdat;
  logic        wb_ack, wb_err, wb_stall;
  logic [31:0] wb_rdat;

  int checks = 0;
  int errors = 0;

  riscv_wb_arbiter #(.OUTST_W(OutstW)) dut (
    .clk_i     (clk),
    .reset_ni  (rst_n),
    .i_cyc_i   (i_cyc),
    .i_stb_i   (i_stb),
    .i_we_i    (i_we),
    .i_addr_i  (i_addr),
    .i_sel_i   (i_sel),
    .i_data_i  (i_wdat),
    .i_ack_o   (i_ack),
    .i_err_o   (i_err),
    .i_stall_o (i_stall),
    .i_data_o  (i_rdat),
    .d_cyc_i   (d_cyc),
    .d_stb_i   (d_stb),
    .d_we_i    (d_we),
    .d_addr_i  (d_addr),
    .d_sel_i   (d_sel),
    .d_data_i  (d_wdat),
    .d_ack_o   (d_ack),
    .d_err_o   (d_err),
    .d_stall_o (d_stall),
    .d_data_o  (d_rdat),
    .wb_cyc_o  (wb_cyc),
    .wb_stb_o  (wb_stb),
    .wb_we_o   (wb_we),
    .wb_addr_o (wb_addr),
    .wb_sel_o  (wb_sel),
    .wb_data_o (wb_wdat),
    .wb_ack_i  (wb_ack),
    .wb_err_i  (wb_err),
    .wb_stall_i(wb_stall),
    .wb_data_i (wb_rdat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner 0 = none, 1 = I, 2 = D; count of in-flight transfers.
  int m_owner = 0;
  int m_count = 0;
  int m_last  = 1;

  always @(negedge clk) begin
    logic        e_wcyc, e_wstb, e_wwe;
    logic [29:0] e_waddr;
    logic [3:0]  e_wsel;
    logic [31:0] e_wdat;
    logic        e_is, e_ds, e_ia, e_da, e_ie, e_de;
    logic [31:0] e_id, e_dd;
    logic        full, resp, own_cyc;
    if (!rst_n) begin
      m_owner = 0;
      m_count = 0;
      m_last  = 1;
    end
    e_wcyc = 0; e_wstb = 0; e_wwe = 0; e_waddr = '0; e_wsel = '0; e_wdat = '0;
    e_is = 1; e_ds = 1; e_ia = 0; e_da = 0; e_ie = 0; e_de = 0; e_id = '0; e_dd = '0;
    full = (m_count == MaxCount);
    resp = (wb_ack || wb_err) && (m_count > 0);
    if (m_owner == 1) begin
      e_wcyc = i_cyc; e_wstb = i_stb && !full; e_wwe = i_we;
      e_waddr = i_addr; e_wsel = i_sel; e_wdat = i_wdat;
      e_is = wb_stall || full;
      e_ia = wb_ack && (m_count > 0);
      e_ie = wb_err && (m_count > 0);
      e_id = wb_rdat;
    end else if (m_owner == 2) begin
      e_wcyc = d_cyc; e_wstb = d_stb && !full; e_wwe = d_we;
      e_waddr = d_addr; e_wsel = d_sel; e_wdat = d_wdat;
      e_ds = wb_stall || full;
      e_da = wb_ack && (m_count > 0);
      e_de = wb_err && (m_count > 0);
      e_dd = wb_rdat;
    end
    chk("wb_cyc", wb_cyc, e_wcyc);
    chk("wb_stb", wb_stb, e_wstb);
    chk("wb_we", wb_we, e_wwe);
    chk("wb_addr", wb_addr, e_waddr);
    chk("wb_sel", wb_sel, e_wsel);
    chk("wb_data", wb_wdat, e_wdat);
    chk("i_stall", i_stall, e_is);
    chk("d_stall", d_stall, e_ds);
    chk("i_ack", i_ack, e_ia);
    chk("d_ack", d_ack, e_da);
    chk("i_err", i_err, e_ie);
    chk("d_err", d_err, e_de);
    chk("i_rdata", i_rdat, e_id);
    chk("d_rdata", d_rdat, e_dd);
    // Advance model to the state after the coming rising edge.
    if (rst_n) begin
      if (m_owner == 0) begin
        if (i_cyc && d_cyc) begin
`ifdef RISCV_ARB_RR_EN
          m_owner = (m_last == 1) ? 2 : 1;
`else
          m_owner = 2;
`endif
        end else if (d_cyc) begin
          m_owner = 2;
        end else if (i_cyc) begin
          m_owner = 1;
        end
        if (m_owner != 0) m_last = m_owner;
        m_count = 0;
      end else begin
        own_cyc = (m_owner == 1) ? i_cyc : d_cyc;
        if (!own_cyc) begin
          m_owner = 0;
          m_count = 0;
        end else begin
          if (e_wstb && !wb_stall) m_count++;
          if (resp) m_count--;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    i_cyc = 0; i_stb = 0; i_we = 0; i_addr = '0; i_sel = '0; i_wdat = '0;
    d_cyc = 0; d_stb = 0; d_we = 0; d_addr = '0; d_sel = '0; d_wdat = '0;
    wb_ack = 0; wb_err = 0; wb_stall = 0; wb_rdat = 32'hCAFE_0001;
  endtask

  initial begin
    logic exp_d;
    rst_n = 1'b0;
    clear_all();
    // Reset state
    @(negedge clk);
    chk("rst_wb_cyc", wb_cyc, 0);
    chk("rst_wb_stb", wb_stb, 0);
    chk("rst_i_stall", i_stall, 1);
    chk("rst_d_stall", d_stall, 1);
    chk("rst_i_ack", i_ack, 0);
    step(); rst_n = 1'b1;
    step();

    // Single instruction fetch with one-cycle arbitration latency
    step(); i_cyc = 1; i_stb = 1; i_addr = 30'h10;
    @(negedge clk);
    chk("t1_idle_stall", i_stall, 1);
    chk("t1_idle_cyc", wb_cyc, 0);
    step();
    @(negedge clk);
    chk("t1_own_cyc", wb_cyc, 1);
    chk("t1_own_stb", wb_stb, 1);
    chk("t1_addr", wb_addr, 32'h10);
    chk("t1_stall", i_stall, 0);
    step(); i_stb = 0; wb_ack = 1;
    @(negedge clk);
    chk("t1_i_ack", i_ack, 1);
    chk("t1_d_ack", d_ack, 0);
    step(); wb_ack = 0;
    @(negedge clk);
    chk("t1_i_ack_low", i_ack, 0);
    step(); i_cyc = 0;
    @(negedge clk);
    chk("t1_release_cyc", wb_cyc, 0);
    step();

    // Contention: D wins, I waits for one IDLE cycle after D releases
    step(); i_cyc = 1; d_cyc = 1;
    step();
    @(negedge clk);
    chk("t2_d_stall", d_stall, 0);
    chk("t2_i_stall", i_stall, 1);
    step(); d_cyc = 0;
    @(negedge clk);
    chk("t2_rel_i_stall", i_stall, 1);
    step();
    @(negedge clk);
    chk("t2_gap_i_stall", i_stall, 1);
    chk("t2_gap_cyc", wb_cyc, 0);
    step();
    @(negedge clk);
    chk("t2_i_own_stall", i_stall, 0);
    chk("t2_i_own_cyc", wb_cyc, 1);
    step(); i_cyc = 0;
    step();

    // Repeated contention: D, I, D with round-robin; D every time with fixed priority
    for (int k = 0; k < 3; k++) begin
      step(); i_cyc = 1; d_cyc = 1;
      step();
      @(negedge clk);
`ifdef RISCV_ARB_RR_EN
      exp_d = (k != 1);
`else
      exp_d = 1'b1;
`endif
      chk("t3_d_grant", !d_stall, exp_d);
      chk("t3_i_grant", !i_stall, !exp_d);
      step(); i_cyc = 0; d_cyc = 0;
      step();
    end

    // Outstanding limit: three accepted, fourth stalls until an ACK retires one
    step(); i_cyc = 1; i_stb = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("t4_acc_stall", i_stall, 0);
      chk("t4_acc_stb", wb_stb, 1);
    end
    step();
    @(negedge clk);
    chk("t4_full_stall", i_stall, 1);
    chk("t4_full_stb", wb_stb, 0);
    step(); wb_ack = 1;
    @(negedge clk);
    chk("t4_ack", i_ack, 1);
    chk("t4_ack_stall", i_stall, 1);
    step(); wb_ack = 0;
    @(negedge clk);
    chk("t4_resume_stall", i_stall, 0);
    chk("t4_resume_stb", wb_stb, 1);
    step(); i_stb = 0; wb_ack = 1;
    // Abort with two outstanding; late ACKs must go nowhere
    step(); wb_ack = 0; i_cyc = 0;
    @(negedge clk);
    chk("t5_rel_cyc", wb_cyc, 0);
    step(); wb_ack = 1;
    @(negedge clk);
    chk("t5_late_i_ack", i_ack, 0);
    chk("t5_late_d_ack", d_ack, 0);
    chk("t5_idle_stall", i_stall, 1);
    step();
    @(negedge clk);
    chk("t5_late2_i_ack", i_ack, 0);
    step(); wb_ack = 0;
    // Counter restarted from zero: three accepted again, fourth stalls
    step(); i_cyc = 1; i_stb = 1;
    step(); step(); step();
    @(negedge clk);
    chk("t5_third_stall", i_stall, 0);
    step();
    @(negedge clk);
    chk("t5_fourth_stall", i_stall, 1);
    step(); i_stb = 0; i_cyc = 0;
    step();

    // Same-cycle accept + ACK/ERR leaves the count unchanged
    step(); d_cyc = 1; d_stb = 1;
    step();
    step(); wb_ack = 1;
    @(negedge clk);
    chk("t6_d_ack", d_ack, 1);
    step(); wb_ack = 0; wb_err = 1;
    @(negedge clk);
    chk("t6_d_err", d_err, 1);
    chk("t6_err_stall", d_stall, 0);
    step(); wb_err = 0;
    step();
    @(negedge clk);
    chk("t6_last_acc_stall", d_stall, 0);
    step();
    @(negedge clk);
    chk("t6_full_stall", d_stall, 1);
    step(); d_stb = 0; d_cyc = 0;
    step();

    // Randomized traffic against the model, with one reset mid-run
    for (int n = 0; n < 3000; n++) begin
      step();
      if (n == 1500) rst_n = 1'b0;
      if (n == 1502) rst_n = 1'b1;
      if (i_cyc) i_cyc = ($urandom_range(0, 9) != 0);
      else       i_cyc = ($urandom_range(0, 3) == 0);
      if (d_cyc) d_cyc = ($urandom_range(0, 9) != 0);
      else       d_cyc = ($urandom_range(0, 3) == 0);
      i_stb  = i_cyc && ($urandom_range(0, 1) == 0);
      d_stb  = d_cyc && ($urandom_range(0, 1) == 0);
      i_we   = 1'($urandom);
      d_we   = 1'($urandom);
      i_addr = 30'($urandom);
      d_addr = 30'($urandom);
      i_sel  = 4'($urandom);
      d_sel  = 4'($urandom);
      i_wdat = $urandom;
      d_wdat = $urandom;
      wb_stall = ($urandom_range(0, 3) == 0);
      wb_ack   = ($urandom_range(0, 2) == 0);
      wb_err   = !wb_ack && ($urandom_range(0, 15) == 0);
      wb_rdat  = $urandom;
    end
    step();
    clear_all();
    step();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
